// File: rtl/controller_fsm_param_if.sv
// Control bus between the parametrised CPU controller and its datapath.
// The controller takes the master modport; the datapath takes the slave modport.
interface controller_fsm_param_if #(
  parameter int INSTR_W   = 16,
  parameter int RF_ADDR_W = 4,
  parameter int DADDR_W   = 8,
  parameter int PC_W      = 8,
  parameter int ALU_SEL_W = 3,
  parameter int CNT_W     = 16
) ();
  logic [INSTR_W-1:0]   instruction;
  logic                 RFAZero;
  logic                 Resume;
  logic [ALU_SEL_W-1:0] ALUSelect;
  logic [3:0]           CurrentStateOut;
  logic [3:0]           NextStateOut;
  logic [DADDR_W-1:0]   DAddr;
  logic                 DWrite;
  logic                 IRLd;
  logic                 PCClr;
  logic                 PCUp;
  logic                 PCLd;
  logic [PC_W-1:0]      PCLdValue;
  logic [RF_ADDR_W-1:0] RFAReadAddr;
  logic [RF_ADDR_W-1:0] RFBReadAddr;
  logic [1:0]           RFSelect;
  logic [DADDR_W-1:0]   RFImm;
  logic [RF_ADDR_W-1:0] RFWriteAddr;
  logic                 RFWriteEnable;
  logic                 Halted;
  logic                 Err;
  logic [CNT_W-1:0]     RetireCount;

  modport master (
    input  instruction, RFAZero, Resume,
    output ALUSelect, CurrentStateOut, NextStateOut, DAddr, DWrite, IRLd,
           PCClr, PCUp, PCLd, PCLdValue, RFAReadAddr, RFBReadAddr, RFSelect,
           RFImm, RFWriteAddr, RFWriteEnable, Halted, Err, RetireCount
  );

  modport slave (
    output instruction, RFAZero, Resume,
    input  ALUSelect, CurrentStateOut, NextStateOut, DAddr, DWrite, IRLd,
           PCClr, PCUp, PCLd, PCLdValue, RFAReadAddr, RFBReadAddr, RFSelect,
           RFImm, RFWriteAddr, RFWriteEnable, Halted, Err, RetireCount
  );
endinterface

// File: rtl/controller_fsm_param.sv
// Fetch/decode/execute sequencer for the 16-bit CPU datapath with load wait,
// immediate load, jumps, resumable HALT, sticky illegal-opcode trap and retire counter.
module controller_fsm_param #(
  parameter int INSTR_W   = 16,
  parameter int OPC_W     = 4,
  parameter int RF_ADDR_W = 4,
  parameter int DADDR_W   = 8,
  parameter int PC_W      = 8,
  parameter int ALU_SEL_W = 3,
  parameter int MEM_WAIT  = 1,
  parameter int CNT_W     = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  controller_fsm_param_if.master bus
);
  localparam int WAIT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  typedef enum logic [3:0] {
    ST_NOOP      = 4'b0000,
    ST_STORE     = 4'b0001,
    ST_LOAD_WAIT = 4'b0010,
    ST_ADD       = 4'b0011,
    ST_SUB       = 4'b0100,
    ST_HALT      = 4'b0101,
    ST_LOAD_WB   = 4'b0110,
    ST_LDI       = 4'b0111,
    ST_INIT      = 4'b1000,
    ST_JMP       = 4'b1001,
    ST_JZ        = 4'b1010,
    ST_DECODE    = 4'b1100,
    ST_TRAP      = 4'b1110,
    ST_FETCH     = 4'b1111
  } state_t;

  state_t             state_reg, state_next;
  logic [WAIT_W-1:0]  wait_cnt_reg;
  logic [CNT_W-1:0]   retire_cnt_reg;
  logic               retire;

  logic [OPC_W-1:0]     op;
  logic [RF_ADDR_W-1:0] f_a, f_b, f_w;
  logic [DADDR_W-1:0]   f_m, f_s;
  logic [PC_W-1:0]      f_t;

  assign op  = bus.instruction[INSTR_W-1 -: OPC_W];
  assign f_a = bus.instruction[INSTR_W-OPC_W-1 -: RF_ADDR_W];
  assign f_b = bus.instruction[INSTR_W-OPC_W-RF_ADDR_W-1 -: RF_ADDR_W];
  assign f_w = bus.instruction[RF_ADDR_W-1:0];
  assign f_m = bus.instruction[RF_ADDR_W +: DADDR_W];
  assign f_s = bus.instruction[DADDR_W-1:0];
  assign f_t = bus.instruction[PC_W-1:0];

  always_comb begin
    state_next        = ST_INIT;
    retire            = 1'b0;
    bus.ALUSelect     = '0;
    bus.DAddr         = '0;
    bus.DWrite        = 1'b0;
    bus.IRLd          = 1'b0;
    bus.PCClr         = 1'b0;
    bus.PCUp          = 1'b0;
    bus.PCLd          = 1'b0;
    bus.PCLdValue     = '0;
    bus.RFAReadAddr   = '0;
    bus.RFBReadAddr   = '0;
    bus.RFSelect      = 2'd0;
    bus.RFImm         = '0;
    bus.RFWriteAddr   = '0;
    bus.RFWriteEnable = 1'b0;
    bus.Halted        = 1'b0;
    bus.Err           = 1'b0;
    case (state_reg)
      ST_INIT: begin
        bus.PCClr  = 1'b1;
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        bus.PCUp   = 1'b1;
        bus.IRLd   = 1'b1;
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        case (op)
          OPC_W'(0): state_next = ST_NOOP;
          OPC_W'(1): state_next = ST_STORE;
          OPC_W'(2): state_next = ST_LOAD_WAIT;
          OPC_W'(3): state_next = ST_ADD;
          OPC_W'(4): state_next = ST_SUB;
          OPC_W'(5): state_next = ST_HALT;
          OPC_W'(6): state_next = ST_LDI;
          OPC_W'(7): state_next = ST_JMP;
          OPC_W'(8): state_next = ST_JZ;
          default:   state_next = ST_TRAP;
        endcase
      end
      ST_NOOP: begin
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_STORE: begin
        bus.DAddr       = f_s;
        bus.RFAReadAddr = f_a;
        bus.DWrite      = 1'b1;
        retire          = 1'b1;
        state_next      = ST_FETCH;
      end
      ST_LOAD_WAIT: begin
        bus.DAddr       = f_m;
        bus.RFSelect    = 2'd1;
        bus.RFWriteAddr = f_w;
        state_next      = (wait_cnt_reg == '0) ? ST_LOAD_WB : ST_LOAD_WAIT;
      end
      ST_LOAD_WB: begin
        bus.DAddr         = f_m;
        bus.RFSelect      = 2'd1;
        bus.RFWriteAddr   = f_w;
        bus.RFWriteEnable = 1'b1;
        retire            = 1'b1;
        state_next        = ST_FETCH;
      end
      ST_ADD, ST_SUB: begin
        bus.RFAReadAddr   = f_a;
        bus.RFBReadAddr   = f_b;
        bus.RFWriteAddr   = f_w;
        bus.ALUSelect     = (state_reg == ST_ADD) ? ALU_SEL_W'(1) : ALU_SEL_W'(2);
        bus.RFWriteEnable = 1'b1;
        retire            = 1'b1;
        state_next        = ST_FETCH;
      end
      ST_LDI: begin
        bus.RFSelect      = 2'd2;
        bus.RFImm         = f_m;
        bus.RFWriteAddr   = f_w;
        bus.RFWriteEnable = 1'b1;
        retire            = 1'b1;
        state_next        = ST_FETCH;
      end
      ST_JMP: begin
        bus.PCLd      = 1'b1;
        bus.PCLdValue = f_t;
        retire        = 1'b1;
        state_next    = ST_FETCH;
      end
      ST_JZ: begin
        bus.RFAReadAddr = f_a;
        bus.PCLdValue   = f_t;
        bus.PCLd        = bus.RFAZero;
        retire          = 1'b1;
        state_next      = ST_FETCH;
      end
      ST_HALT: begin
        bus.Halted = 1'b1;
        retire     = bus.Resume;
        state_next = bus.Resume ? ST_FETCH : ST_HALT;
      end
      ST_TRAP: begin
        bus.Err    = 1'b1;
        state_next = ST_TRAP;
      end
      default: state_next = ST_INIT;
    endcase
  end

  // The wait counter holds remaining LOAD_WAIT cycles minus one.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg      <= ST_INIT;
      wait_cnt_reg   <= '0;
      retire_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_DECODE && state_next == ST_LOAD_WAIT)
        wait_cnt_reg <= WAIT_W'(MEM_WAIT - 1);
      else if (state_reg == ST_LOAD_WAIT && wait_cnt_reg != '0)
        wait_cnt_reg <= wait_cnt_reg - 1'b1;
      if (retire)
        retire_cnt_reg <= retire_cnt_reg + 1'b1;
    end
  end

  assign bus.CurrentStateOut = state_reg;
  assign bus.NextStateOut    = state_next;
  assign bus.RetireCount     = retire_cnt_reg;
endmodule

// File: tb/tb_controller_fsm_param.sv
// Directed bench: three controller instances (MEM_WAIT=3, MEM_WAIT=1, CNT_W=2)
// driven through their control-bus interfaces with hand-computed expectations.
module tb_controller_fsm_param;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 Clk = ~Clk;

  controller_fsm_param_if #(.CNT_W(16)) if_a ();
  controller_fsm_param_if #(.CNT_W(16)) if_b ();
  controller_fsm_param_if #(.CNT_W(2))  if_c ();

  controller_fsm_param #(.MEM_WAIT(3), .CNT_W(16)) dut_a (.Clk(Clk), .Rst(Rst), .bus(if_a));
  controller_fsm_param #(.MEM_WAIT(1), .CNT_W(16)) dut_b (.Clk(Clk), .Rst(Rst), .bus(if_b));
  controller_fsm_param #(.MEM_WAIT(1), .CNT_W(2))  dut_c (.Clk(Clk), .Rst(Rst), .bus(if_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // From FETCH: load an instruction into dut_a and advance to its first execute cycle.
  task automatic issue_a(input logic [15:0] ins);
    if_a.instruction = ins;
    tick();
    tick();
  endtask

  initial begin
    if_a.instruction = '0; if_a.RFAZero = 1'b0; if_a.Resume = 1'b0;
    if_b.instruction = '0; if_b.RFAZero = 1'b0; if_b.Resume = 1'b0;
    if_c.instruction = '0; if_c.RFAZero = 1'b0; if_c.Resume = 1'b0;

    // Reset and first fetch
    tick(); tick();
    check("rst_state", if_a.CurrentStateOut, 4'b1000);
    check("rst_pcclr", if_a.PCClr, 1);
    check("rst_retire", if_a.RetireCount, 0);
    Rst = 1'b0;
    tick();
    check("fetch_state", if_a.CurrentStateOut, 4'b1111);
    check("fetch_pcup", if_a.PCUp, 1);
    check("fetch_irld", if_a.IRLd, 1);

    // ADD 0x3125
    if_a.instruction = 16'h3125;
    tick();
    check("dec_state", if_a.CurrentStateOut, 4'b1100);
    check("dec_next_add", if_a.NextStateOut, 4'b0011);
    tick();
    check("add_rfa", if_a.RFAReadAddr, 1);
    check("add_rfb", if_a.RFBReadAddr, 2);
    check("add_rfw", if_a.RFWriteAddr, 5);
    check("add_alu", if_a.ALUSelect, 1);
    check("add_we", if_a.RFWriteEnable, 1);
    check("add_retire0", if_a.RetireCount, 0);
    tick();
    check("add_done_we", if_a.RFWriteEnable, 0);
    check("add_retire1", if_a.RetireCount, 1);

    // SUB 0x4125
    issue_a(16'h4125);
    check("sub_state", if_a.CurrentStateOut, 4'b0100);
    check("sub_alu", if_a.ALUSelect, 2);
    check("sub_rfa", if_a.RFAReadAddr, 1);
    check("sub_rfb", if_a.RFBReadAddr, 2);
    check("sub_rfw", if_a.RFWriteAddr, 5);
    tick();
    check("sub_retire", if_a.RetireCount, 2);

    // LOAD 0x2AB3, MEM_WAIT=3: three wait cycles then write-back
    issue_a(16'h2AB3);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ld3_state%0d", k), if_a.CurrentStateOut, (k < 3) ? 4'b0010 : 4'b0110);
      check($sformatf("ld3_daddr%0d", k), if_a.DAddr, 8'hAB);
      check($sformatf("ld3_rfsel%0d", k), if_a.RFSelect, 1);
      check($sformatf("ld3_rfw%0d", k), if_a.RFWriteAddr, 3);
      check($sformatf("ld3_we%0d", k), if_a.RFWriteEnable, (k == 3) ? 1 : 0);
      tick();
    end
    check("ld3_back_fetch", if_a.CurrentStateOut, 4'b1111);
    check("ld3_retire", if_a.RetireCount, 3);

    // JZ 0x8340 taken / not taken
    if_a.RFAZero = 1'b1;
    issue_a(16'h8340);
    check("jz_pcld_taken", if_a.PCLd, 1);
    check("jz_target", if_a.PCLdValue, 8'h40);
    check("jz_rfa", if_a.RFAReadAddr, 3);
    if_a.RFAZero = 1'b0;
    #1;
    check("jz_pcld_not", if_a.PCLd, 0);
    tick();
    check("jz_retire", if_a.RetireCount, 4);

    // JMP 0x70FF
    issue_a(16'h70FF);
    check("jmp_pcld", if_a.PCLd, 1);
    check("jmp_target", if_a.PCLdValue, 8'hFF);
    tick();
    check("jmp_retire", if_a.RetireCount, 5);

    // HALT 0x5000 held, then Resume
    issue_a(16'h5000);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("halt_hold%0d", k), {if_a.CurrentStateOut, 3'b000, if_a.Halted}, {4'b0101, 4'b0001});
      tick();
    end
    check("halt_retire_held", if_a.RetireCount, 5);
    if_a.Resume = 1'b1;
    tick();
    if_a.Resume = 1'b0;
    check("resume_fetch", if_a.CurrentStateOut, 4'b1111);
    check("resume_retire", if_a.RetireCount, 6);

    // LDI 0x6A57
    issue_a(16'h6A57);
    check("ldi_imm", if_a.RFImm, 8'hA5);
    check("ldi_sel", if_a.RFSelect, 2);
    check("ldi_rfw", if_a.RFWriteAddr, 7);
    check("ldi_we", if_a.RFWriteEnable, 1);
    tick();
    check("ldi_retire", if_a.RetireCount, 7);

    // Asynchronous reset mid-LOAD_WAIT
    issue_a(16'h2AB3);
    tick();
    check("ld_mid_state", if_a.CurrentStateOut, 4'b0010);
    #2 Rst = 1'b1;
    #1;
    check("async_rst_state", if_a.CurrentStateOut, 4'b1000);
    check("async_rst_retire", if_a.RetireCount, 0);
    tick();
    Rst = 1'b0;
    tick();

    // Illegal opcode 0xF000 traps; Resume ignored
    if_a.instruction = 16'hF000;
    tick();
    check("ill_next", if_a.NextStateOut, 4'b1110);
    tick();
    check("trap_err", if_a.Err, 1);
    if_a.Resume = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("trap_hold%0d", k), {if_a.CurrentStateOut, 3'b000, if_a.Err}, {4'b1110, 4'b0001});
    end
    check("trap_retire", if_a.RetireCount, 0);
    if_a.Resume = 1'b0;
    if_a.instruction = 16'h0000;
    Rst = 1'b1;
    #1;
    check("trap_rst", if_a.CurrentStateOut, 4'b1000);
    tick();
    Rst = 1'b0;

    // dut_b: LOAD with MEM_WAIT=1; dut_c: NOOP stream with 2-bit retire counter
    tick();
    check("b_fetch", if_b.CurrentStateOut, 4'b1111);
    if_b.instruction = 16'h2AB3;
    tick();
    tick();
    check("ld1_wait_state", if_b.CurrentStateOut, 4'b0010);
    check("ld1_wait_we", if_b.RFWriteEnable, 0);
    check("ld1_wait_daddr", if_b.DAddr, 8'hAB);
    tick();
    check("ld1_wb_state", if_b.CurrentStateOut, 4'b0110);
    check("ld1_wb_we", if_b.RFWriteEnable, 1);
    check("ld1_wb_daddr", if_b.DAddr, 8'hAB);
    tick();
    check("ld1_back_fetch", if_b.CurrentStateOut, 4'b1111);
    check("c_retire1", if_c.RetireCount, 1);
    for (int i = 2; i <= 4; i++) begin
      tick(); tick(); tick();
      check($sformatf("c_retire%0d", i), if_c.RetireCount, i % 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
